// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: one-word holding buffer feeding a shift register, one bit per clk.
// Optional `SERIALIZER_PARITY_EN appends an even-parity bit after each word's data bits.
module bit_serializer #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          LSB_FIRST  = 1'b0,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

`ifdef SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {StIdle, StShift, StParity} state_e;
`else
  typedef enum logic [0:0] {StIdle, StShift} state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             frame_start_q, frame_start_d;
`ifdef SERIALIZER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic accept;
  logic load;
  logic cur_bit_d;

  // Accept and load are mutually exclusive via hold_full_q, so there is no bypass path.
  assign accept = data_valid && !hold_full_q;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    load        = 1'b0;
`ifdef SERIALIZER_PARITY_EN
    parity_d    = parity_q;
`endif

    unique case (state_q)
      StIdle: begin
        bit_cnt_d = '0;
        load      = hold_full_q;
      end
      StShift: begin
        shift_d   = LSB_FIRST ? (shift_q >> 1) : (shift_q << 1);
        bit_cnt_d = bit_cnt_q + CntW'(1);
        if (bit_cnt_q == LastCnt) begin
`ifdef SERIALIZER_PARITY_EN
          state_d = StParity;
`else
          load      = hold_full_q;
          state_d   = StIdle;
          bit_cnt_d = '0;
`endif
        end
      end
`ifdef SERIALIZER_PARITY_EN
      StParity: begin
        load      = hold_full_q;
        state_d   = StIdle;
        bit_cnt_d = '0;
      end
`endif
      default: state_d = StIdle;
    endcase

    if (load) begin
      shift_d     = hold_q;
      bit_cnt_d   = '0;
      state_d     = StShift;
      hold_full_d = 1'b0;
`ifdef SERIALIZER_PARITY_EN
      parity_d    = ^hold_q;
`endif
    end

    if (accept) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end
  end

  // Output flops are computed from next state so ser_out lines up with state_q.
  always_comb begin
    cur_bit_d     = LSB_FIRST ? shift_d[0] : shift_d[WIDTH-1];
    ser_valid_d   = (state_d != StIdle);
    frame_start_d = load;
    ser_out_d     = IDLE_LEVEL;
    if (state_d == StShift) begin
      ser_out_d = cur_bit_d;
    end
`ifdef SERIALIZER_PARITY_EN
    if (state_d == StParity) begin
      ser_out_d = parity_d;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      ser_out_q     <= IDLE_LEVEL;
      ser_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      parity_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      ser_out_q     <= ser_out_d;
      ser_valid_q   <= ser_valid_d;
      frame_start_q <= frame_start_d;
`ifdef SERIALIZER_PARITY_EN
      parity_q      <= parity_d;
`endif
    end
  end

  assign data_ready  = !hold_full_q;
  assign ser_out     = ser_out_q;
  assign ser_valid   = ser_valid_q;
  assign frame_start = frame_start_q;
  assign busy        = (state_q != StIdle) || hold_full_q;

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Parallel-to-serial front end that feeds the run-length sequence detector's serial input `w`, one bit per clk.
- Accepts WIDTH-bit words over a valid/ready handshake into a one-word holding buffer.
- Shifts each word out on `ser_out`, MSB-first by default.
- Back-to-back words stream with no idle gap, so the downstream detector sees runs that cross word boundaries.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- LSB_FIRST, 0, 0 = shift MSB first, 1 = shift LSB first.
- IDLE_LEVEL, 0, value driven on `ser_out` while no word is being shifted.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- data_in  in  WIDTH  parallel word.
- data_valid  in  1  data_in is valid this cycle.
- data_ready  out  1  holding buffer can accept a word.
- ser_out  out  1  serial bit, registered; connects to detector `w`.
- ser_valid  out  1  ser_out carries a data (or parity) bit this cycle.
- frame_start  out  1  high during the first bit of each word.
- busy  out  1  shifting in progress, or holding buffer occupied.

Behaviour:
- Reset values: ser_out=IDLE_LEVEL, ser_valid=0, frame_start=0, data_ready=1, busy=0. Internal state: FSM=IDLE, hold buffer empty, bit_cnt=0.
- Reset mid-word abandons the current word and the held word. No partial bits appear after reset deasserts.
- Handshake:
  - Accept occurs on any edge where data_valid && data_ready.
  - data_ready = !hold_full (combinational from register).
  - data_in must be stable only in the accept cycle.
  - data_valid while data_ready=0 is ignored; the word is not captured.
- Load (hold -> shift register): when FSM is IDLE, or on the final bit of the current word, and hold_full=1:
  - Shift register loads from hold, hold_full clears, bit_cnt=0, FSM goes to SHIFT.
  - A new accept may occur in the same cycle the hold buffer is emptied only if hold_full was already 0. There is no bypass.
- Latency: word accepted at edge E0 (FSM IDLE) -> first bit on ser_out after edge E1 -> last data bit after edge E1+WIDTH-1.
- FSM states:
  - IDLE: ser_valid=0, ser_out=IDLE_LEVEL. Go to SHIFT on load.
  - SHIFT:
    - ser_valid=1, ser_out=current bit, bit_cnt increments each edge.
    - At bit_cnt=WIDTH-1: go to PARITY if PARITY_EN is defined; else load the next word if hold_full, otherwise go to IDLE.
  - PARITY (PARITY_EN only): one cycle, ser_valid=1, ser_out=parity bit. Then load if hold_full, else go to IDLE.
- frame_start=1 exactly in the cycle the first bit of a word is on ser_out; 0 on parity bits.
- Back-to-back: if hold_full at the final bit, the next word's first bit follows in the very next cycle. ser_valid stays 1 continuously.
- Bit order:
  - LSB_FIRST=0 emits data_in[WIDTH-1] down to [0].
  - LSB_FIRST=1 emits [0] up to [WIDTH-1].
- bit_cnt width is $clog2(WIDTH+1). No wrap-around beyond WIDTH-1.
- busy = (FSM != IDLE) || hold_full.

Optional Feature:
- Macro: SERIALIZER_PARITY_EN.
- Defined: after each word's WIDTH data bits, one extra even-parity bit (XOR of all data bits) is emitted with ser_valid=1. The per-word frame becomes WIDTH+1 cycles, and the PARITY state exists.
- Undefined: no PARITY state and no parity logic. The frame is exactly WIDTH cycles.

Test Plan:
- Reset then idle 10 cycles -> ser_out=0, ser_valid=0, data_ready=1, busy=0 throughout.
- WIDTH=8, accept 8'hA5 from IDLE -> from E1: ser_out 1,0,1,0,0,1,0,1; ser_valid high 8 cycles; frame_start high only on the first bit; then IDLE.
- Accept 8'hF0, then 8'h0F as soon as data_ready returns -> 16 contiguous ser_valid cycles with bits 1111_0000_0000_1111; frame_start at bits 0 and 8. The downstream detector must see z=1 for the 8-zero run.
- Hold full while shifting, data_valid held high -> data_ready=0 and the third word is not captured until the hold buffer drains; no word lost or duplicated.
- Assert reset at bit 3 of 8'hC3 with a word held -> next cycle ser_out=IDLE_LEVEL, ser_valid=0, data_ready=1; the held word is never emitted.
- SERIALIZER_PARITY_EN, words 8'hA5 then 8'h07 -> parity bits 0 and 1 respectively; 9-cycle frames; frame_start low on parity cycles.
